// File: rtl/bist_pkg.sv
// Shared definitions for the BIST MISR slice.
//   WIDTH_DEF : default response/signature width
//   TAP_MASK  : feedback taps (bits 0, 2, 3, 5), shared with the pattern LFSR
//   state_e   : controller FSM states
package bist_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam logic [15:0] TAP_MASK  = 16'h002D;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bist_misr_misr16.sv
// misr16 -- multiple-input signature register.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears the signature
//   clr  : synchronous clear (takes priority over en)
//   en   : compact resp into the signature this cycle
//   resp : response word
//   sig  : current signature
module misr16
  import bist_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] sig
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(TAP_MASK);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  // Shift toward bit 0; the tap parity enters at the MSB, then XOR the response.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {^(sig_q & MASK), sig_q[WIDTH-1:1]} ^ resp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_misr.sv
// bist_misr -- BIST response compactor and signature checker.
// Compacts N_PATTERNS responses into a MISR, then compares against GOLDEN.
// Optional watchdog: define BIST_MISR_TIMEOUT_EN to abort a run after TIMEOUT
// idle cycles without resp_valid.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : pulse, begins a run from IDLE or DONE
//   resp       : circuit-under-test response
//   resp_valid : capture resp this cycle (RUN only)
//   busy       : high in RUN and CHECK
//   done       : high in DONE until next start/rst
//   pass       : signature matched GOLDEN (valid while done)
//   signature  : current MISR contents
//   timeout    : run aborted by watchdog (0 when watchdog not built)
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter logic [15:0] N_PATTERNS = 16'd1000,
  parameter logic [15:0] GOLDEN     = 16'h0000,
  parameter logic [15:0] TIMEOUT    = 16'd64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] resp,
  input  logic             resp_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic             timeout
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        pass_q, pass_d;
  logic        misr_clr;
  logic        misr_en;
  logic [15:0] count_inc;

  assign count_inc = count_q + 16'd1;

`ifdef BIST_MISR_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
  logic        tmo_q, tmo_d;
  logic [15:0] idle_inc;

  assign idle_inc = idle_q + 16'd1;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
`ifdef BIST_MISR_TIMEOUT_EN
    idle_d   = idle_q;
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          count_d  = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
`ifdef BIST_MISR_TIMEOUT_EN
          idle_d   = '0;
          tmo_d    = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (resp_valid) begin
          misr_en = 1'b1;
          if (count_q != N_PATTERNS) begin
            count_d = count_inc;
          end
          if (count_inc == N_PATTERNS) begin
            state_d = S_CHECK;
          end
`ifdef BIST_MISR_TIMEOUT_EN
          idle_d = '0;
        end else begin
          idle_d = idle_inc;
          if (idle_inc == TIMEOUT) begin
            state_d = S_DONE;
            tmo_d   = 1'b1;
            pass_d  = 1'b0;
          end
`endif
        end
      end
      S_CHECK: begin
        // Signature already holds the final capture; register the verdict.
        pass_d  = (signature == WIDTH'(GOLDEN));
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pass_q  <= pass_d;
    end
  end

`ifdef BIST_MISR_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  misr16 #(
    .WIDTH(WIDTH)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .resp(resp),
    .sig (signature)
  );

  assign busy = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done = (state_q == S_DONE);
  assign pass = pass_q;

endmodule

// File: doc/bist_misr.md
BIST_MISR -- requirements
Module: bist_misr

Interface
REQ-001 Parameter: WIDTH, 16, width of the response bus and the signature register.
REQ-002 Parameter: N_PATTERNS, 16'd1000, number of responses compacted per run (1..65535).
REQ-003 Parameter: GOLDEN, 16'h0000, expected final signature.
REQ-004 Parameter: TIMEOUT, 16'd64, maximum idle cycles between responses (used only under REQ-021).
REQ-005 Port: clk  input  1  single clock; all state on rising edge.
REQ-006 Port: rst  input  1  reset; asynchronous, active-high.
REQ-007 Port: start  input  1  one-cycle pulse that begins a run.
REQ-008 Port: resp  input  WIDTH  circuit-under-test response, paired with the 16-bit LFSR pattern stream.
REQ-009 Port: resp_valid  input  1  resp is captured on this cycle.
REQ-010 Port: busy  output  1  high in RUN and CHECK.
REQ-011 Port: done  output  1  high in DONE; held until the next start or rst.
REQ-012 Port: pass  output  1  valid while done is high; 1 when signature == GOLDEN.
REQ-013 Port: signature  output  WIDTH  current MISR contents.
REQ-014 Port: timeout  output  1  run aborted by watchdog; tied 0 when REQ-021 is not compiled in.

Function
REQ-015 FSM states: IDLE, RUN, CHECK, DONE. Transitions: IDLE -start-> RUN; RUN -(N_PATTERNS-th capture)-> CHECK; CHECK -> DONE unconditionally after one cycle; DONE -start-> RUN.
REQ-016 On entry to RUN: signature = 16'h0000, pattern count = 0, pass = 0, timeout = 0.
REQ-017 MISR update, only in RUN with resp_valid=1: sig'[15] = sig[0]^sig[2]^sig[3]^sig[5]^resp[15]; sig'[i] = sig[i+1]^resp[i] for i = 0..14 (same feedback taps as the pattern LFSR).
REQ-018 pass is registered in CHECK from the final signature; done rises on the cycle after CHECK, i.e. 2 cycles after the last capture edge.
REQ-019 Boundary conditions: resp_valid outside RUN is ignored; start during RUN or CHECK is ignored; start and the final resp_valid in the same cycle: capture is taken and start is ignored; count saturates at N_PATTERNS and never wraps.
REQ-020 signature, pass and done are stable in DONE until the next start.

Configuration
REQ-021 Macro BIST_MISR_TIMEOUT_EN: when defined, a 16-bit idle counter runs in RUN, clears on each resp_valid, and on reaching TIMEOUT moves the FSM to DONE with pass=0 and timeout=1. When undefined, no watchdog exists, RUN waits indefinitely, and timeout is constant 0.

Reset
REQ-022 rst asserted at any time, including mid-run, forces IDLE immediately and asynchronously: signature=16'h0000, count=0, busy=0, done=0, pass=0, timeout=0.
REQ-023 After rst deasserts, the FSM stays in IDLE until start.

Structure
REQ-024 Shared package bist_pkg holds: the WIDTH default, the tap mask constant 16'h002D (bits 0, 2, 3, 5), and the FSM state enum.
REQ-025 Sub-module misr16 holds the signature register and next-state XOR network (inputs clk, rst, clr, en, resp); bist_misr holds the FSM, counters and compare.

Verification
REQ-026 N_PATTERNS=1, GOLDEN=16'h0001, start, then resp=16'h0001 with resp_valid -> signature=16'h0001, done 2 cycles later, pass=1.
REQ-027 N_PATTERNS=2, GOLDEN=16'h8000, responses 16'h0001 then 16'h0000 -> signature=16'h8000, pass=1; the same run with GOLDEN=16'h8001 gives pass=0.
REQ-028 resp_valid pulses while in IDLE and DONE -> signature unchanged; a start pulse during RUN -> count is not reset.
REQ-029 rst asserted mid-run after 5 captures -> busy=0 and signature=0 immediately; a new start completes normally.
REQ-030 With BIST_MISR_TIMEOUT_EN and TIMEOUT=4: start, then no resp_valid -> done=1, timeout=1, pass=0 after 4 idle cycles; without the macro the same stimulus leaves busy=1 indefinitely.
REQ-031 Back-to-back runs: start in DONE -> signature cleared and a second identical run reproduces the same signature.
